// File: rtl/frame_packer_sink_pkg.sv
// Shared definitions for the frame packer sink: the frame FSM encoding and
// a helper that sizes counters so that they are never zero bits wide.
package frame_packer_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Bits needed to index 0..value-1, with a floor of one bit.
  function automatic int cnt_bits(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/frame_packer_sink_if.sv
// Bundle of the result-FIFO read side and the framebuffer write port.
// The master is the sink (pops pixels, writes words); the slave is the
// environment (FIFO and memory).
interface frame_packer_sink_if #(
  parameter int DWIDTH = 8,
  parameter int PACK   = 4,
  parameter int AWIDTH = 20
);
  logic                     fifo_rd_en;
  logic [DWIDTH-1:0]        fifo_dout;
  logic                     fifo_empty;
  logic                     mem_wr_en;
  logic [AWIDTH-1:0]        mem_addr;
  logic [DWIDTH*PACK-1:0]   mem_wdata;
  logic                     mem_ready;

  modport master (
    output fifo_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  fifo_dout, fifo_empty, mem_ready
  );

  modport slave (
    input  fifo_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output fifo_dout, fifo_empty, mem_ready
  );
endinterface

// File: rtl/frame_packer_sink_pixel_packer.sv
// Accumulates PACK pixels into one word, first pixel in the low lane.
// A completed word either bypasses straight to the caller (bypass_i) or is
// held here with full_o set until the caller emits it. emit_i also drains a
// partial word at frame end; unfilled lanes read as zero because the buffer
// is cleared every time a word leaves.
module frame_packer_sink_pixel_packer
  import frame_packer_sink_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PACK   = 4,
  localparam int LW    = cnt_bits(PACK)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [DWIDTH-1:0]      pixel_i,
  input  logic                   bypass_i,
  input  logic                   emit_i,
  output logic [LW-1:0]          lane_o,
  output logic                   full_o,
  output logic [DWIDTH*PACK-1:0] word_o,
  output logic [DWIDTH*PACK-1:0] pop_word_o,
  output logic                   complete_o
);

  localparam logic [LW-1:0] LANE_LAST = LW'(PACK - 1);

  logic [DWIDTH*PACK-1:0] buf_q;
  logic [LW-1:0]          lane_q;
  logic                   full_q;

  // Buffer contents with the incoming pixel dropped into the current lane.
  generate
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
      assign pop_word_o[gi*DWIDTH +: DWIDTH] =
        (lane_q == LW'(gi)) ? pixel_i : buf_q[gi*DWIDTH +: DWIDTH];
    end
  endgenerate

  assign complete_o = push_i && (lane_q == LANE_LAST);
  assign lane_o     = lane_q;
  assign full_o     = full_q;
  assign word_o     = buf_q;

  // Lane/buffer/full update: clear and emit empty the buffer, a push fills a lane.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q  <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else if (clear_i || emit_i) begin
      buf_q  <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else if (push_i) begin
      if (complete_o) begin
        lane_q <= '0;
        if (bypass_i) begin
          buf_q <= '0;
        end else begin
          buf_q  <= pop_word_o;
          full_q <= 1'b1;
        end
      end else begin
        buf_q  <= pop_word_o;
        lane_q <= lane_q + LW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_packer_sink.sv
// Output end of the filter pipeline: drains the FWFT result FIFO one pixel
// per pop, packs PACK pixels per word and writes words to the framebuffer at
// incrementing addresses. A frame is armed by start and ends with a single
// frame_done pulse once the last word has been accepted by memory.
module frame_packer_sink
  import frame_packer_sink_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int PACK       = 4,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int AWIDTH     = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  frame_packer_sink_if.master  bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int XW = cnt_bits(IMG_WIDTH);
  localparam int YW = cnt_bits(IMG_HEIGHT);
  localparam int LW = cnt_bits(PACK);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t                 state_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   wr_en_q;
  logic [AWIDTH-1:0]      addr_q;
  logic [DWIDTH*PACK-1:0] wdata_q;

  logic                   pk_full;
  logic                   pk_complete;
  logic [LW-1:0]          pk_lane;
  logic [DWIDTH*PACK-1:0] pk_word;
  logic [DWIDTH*PACK-1:0] pk_pop_word;

  logic                   out_free;
  logic                   accept;
  logic                   pop;
  logic                   last_pix;
  logic                   clear;
  logic                   pk_emit;
  logic                   load_pop;
  logic                   load;
  logic [DWIDTH*PACK-1:0] load_word;
  logic                   flush_done;

  // The output register can take a word if it is empty or being accepted now.
  assign accept   = wr_en_q && bus.mem_ready;
  assign out_free = !wr_en_q || bus.mem_ready;

  // Pop only while running and the packer is not holding a stalled word.
  // Leaving RUN on the last pixel guarantees no pop past the frame end.
  assign pop      = (state_q == ST_RUN) && !bus.fifo_empty && !pk_full;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  assign clear    = (state_q == ST_IDLE) && start;

  // A stalled full word, or the zero-padded tail at frame end, leaves the packer.
  assign pk_emit  = out_free && (pk_full || ((state_q == ST_FLUSH) && (pk_lane != '0)));
  assign load_pop = pk_complete && out_free;
  assign load     = load_pop || pk_emit;
  assign load_word = load_pop ? pk_pop_word : pk_word;

  // Frame is finished when nothing is left in the packer and the last word
  // is either already gone or leaving this cycle.
  assign flush_done = !pk_full && (pk_lane == '0) && (!wr_en_q || bus.mem_ready);

  frame_packer_sink_pixel_packer #(
    .DWIDTH (DWIDTH),
    .PACK   (PACK)
  ) u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (clear),
    .push_i     (pop),
    .pixel_i    (bus.fifo_dout),
    .bypass_i   (out_free),
    .emit_i     (pk_emit),
    .lane_o     (pk_lane),
    .full_o     (pk_full),
    .word_o     (pk_word),
    .pop_word_o (pk_pop_word),
    .complete_o (pk_complete)
  );

  assign bus.fifo_rd_en = pop;
  assign bus.mem_wr_en  = wr_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

  // Frame FSM with pixel position tracking and registered busy/done flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= ST_RUN;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (pop) begin
            if (last_pix) begin
              state_q <= ST_FLUSH;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: accept happens before load, so a word arriving on the
  // accept cycle keeps wr_en high and lands at the advanced address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (clear) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      if (load) begin
        wr_en_q <= 1'b1;
        wdata_q <= load_word;
      end else if (accept) begin
        wr_en_q <= 1'b0;
      end
      if (accept) begin
        addr_q <= addr_q + AWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_packer_sink.sv
// Directed bench for frame_packer_sink: a 4x2 instance (A) and a 3x2
// instance (B), both PACK=4, each fed by a simple FWFT FIFO model and
// observed by a write/pop/done monitor.
module tb_frame_packer_sink;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic ready_a = 1'b1;
  logic ready_b = 1'b1;
  logic bubble_en = 1'b0;
  logic bubble_ph = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  frame_packer_sink_if #(.DWIDTH(DW), .PACK(PK), .AWIDTH(AW)) bus_a ();
  frame_packer_sink_if #(.DWIDTH(DW), .PACK(PK), .AWIDTH(AW)) bus_b ();

  frame_packer_sink #(
    .DWIDTH(DW), .PACK(PK), .IMG_WIDTH(4), .IMG_HEIGHT(2), .AWIDTH(AW)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .bus(bus_a),
    .busy(busy_a), .frame_done(done_a)
  );

  frame_packer_sink #(
    .DWIDTH(DW), .PACK(PK), .IMG_WIDTH(3), .IMG_HEIGHT(2), .AWIDTH(AW)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .bus(bus_b),
    .busy(busy_b), .frame_done(done_b)
  );

  always #5 clock = ~clock;

  // FIFO models: the initial block appends, the monitors advance the read pointer.
  logic [7:0] fifo_mem_a [0:63];
  logic [7:0] fifo_mem_b [0:63];
  int fifo_cnt_a = 0;
  int fifo_cnt_b = 0;
  int rd_a = 0;
  int rd_b = 0;

  assign bus_a.fifo_empty = (rd_a >= fifo_cnt_a) || (bubble_en && bubble_ph);
  assign bus_a.fifo_dout  = fifo_mem_a[rd_a[5:0]];
  assign bus_a.mem_ready  = ready_a;
  assign bus_b.fifo_empty = (rd_b >= fifo_cnt_b);
  assign bus_b.fifo_dout  = fifo_mem_b[rd_b[5:0]];
  assign bus_b.mem_ready  = ready_b;

  int cyc = 0;
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    bubble_ph <= ~bubble_ph;
  end

  // Monitor A
  logic [AW-1:0] cap_addr_a [0:31];
  logic [31:0]   cap_data_a [0:31];
  int            cap_cyc_a  [0:31];
  int cap_n_a = 0;
  int done_n_a = 0;
  int done_cyc_a = 0;
  int done_run_a = 0;
  int done_maxrun_a = 0;
  int empty_pop_a = 0;
  int unstable_a = 0;
  logic          prev_stall_a = 1'b0;
  logic [AW-1:0] prev_addr_a = '0;
  logic [31:0]   prev_data_a = '0;

  always @(posedge clock) begin
    if (bus_a.fifo_rd_en) begin
      rd_a <= rd_a + 1;
      if (bus_a.fifo_empty) empty_pop_a <= empty_pop_a + 1;
    end
    if (bus_a.mem_wr_en && ready_a) begin
      cap_addr_a[cap_n_a[4:0]] <= bus_a.mem_addr;
      cap_data_a[cap_n_a[4:0]] <= bus_a.mem_wdata;
      cap_cyc_a[cap_n_a[4:0]]  <= cyc;
      cap_n_a <= cap_n_a + 1;
    end
    if (prev_stall_a && (!bus_a.mem_wr_en || bus_a.mem_addr !== prev_addr_a ||
                         bus_a.mem_wdata !== prev_data_a))
      unstable_a <= unstable_a + 1;
    prev_stall_a <= bus_a.mem_wr_en && !ready_a;
    prev_addr_a  <= bus_a.mem_addr;
    prev_data_a  <= bus_a.mem_wdata;
    if (done_a) begin
      done_n_a   <= done_n_a + 1;
      done_cyc_a <= cyc;
      done_run_a <= done_run_a + 1;
      if (done_run_a + 1 > done_maxrun_a) done_maxrun_a <= done_run_a + 1;
    end else begin
      done_run_a <= 0;
    end
  end

  // Monitor B
  logic [AW-1:0] cap_addr_b [0:31];
  logic [31:0]   cap_data_b [0:31];
  int            cap_cyc_b  [0:31];
  int cap_n_b = 0;
  int done_n_b = 0;
  int done_cyc_b = 0;

  always @(posedge clock) begin
    if (bus_b.fifo_rd_en) rd_b <= rd_b + 1;
    if (bus_b.mem_wr_en && ready_b) begin
      cap_addr_b[cap_n_b[4:0]] <= bus_b.mem_addr;
      cap_data_b[cap_n_b[4:0]] <= bus_b.mem_wdata;
      cap_cyc_b[cap_n_b[4:0]]  <= cyc;
      cap_n_b <= cap_n_b + 1;
    end
    if (done_b) begin
      done_n_b   <= done_n_b + 1;
      done_cyc_b <= cyc;
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    fifo_mem_a[fifo_cnt_a[5:0]] = v;
    fifo_cnt_a++;
  endtask

  task automatic push_b(input logic [7:0] v);
    fifo_mem_b[fifo_cnt_b[5:0]] = v;
    fifo_cnt_b++;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int target, input int limit);
    int k;
    k = 0;
    while (done_n_a < target && k < limit) begin
      @(negedge clock);
      k++;
    end
    check(tag, 64'(done_n_a >= target), 64'd1);
  endtask

  task automatic check_word_a(input string tag, input int idx,
                              input logic [AW-1:0] addr, input logic [31:0] data);
    check({tag, "_addr"}, 64'(cap_addr_a[5'(idx)]), 64'(addr));
    check({tag, "_data"}, 64'(cap_data_a[5'(idx)]), 64'(data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p, d, k;

    // ---------------- reset state ----------------
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_wr_en",  64'(bus_a.mem_wr_en),  64'd0);
    check("rst_addr",   64'(bus_a.mem_addr),   64'd0);
    check("rst_wdata",  64'(bus_a.mem_wdata),  64'd0);
    check("rst_busy",   64'(busy_a),           64'd0);
    check("rst_done",   64'(done_a),           64'd0);
    check("rst_rd_en",  64'(bus_a.fifo_rd_en), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // ---------------- basic 4x2 frame ----------------
    c = cap_n_a; p = rd_a; d = done_n_a;
    for (int i = 1; i <= 8; i++) push_a(8'(i));
    pulse_start_a();
    wait_done_a("basic_timeout", d + 1, 60);
    repeat (3) @(negedge clock);
    check("basic_nwords", 64'(cap_n_a - c), 64'd2);
    check_word_a("basic_w0", c, 20'd0, 32'h04030201);
    check_word_a("basic_w1", c + 1, 20'd1, 32'h08070605);
    check("basic_pops", 64'(rd_a - p), 64'd8);
    check("basic_done_lat", 64'(done_cyc_a - cap_cyc_a[5'(c + 1)]), 64'd1);
    check("basic_ndone", 64'(done_n_a - d), 64'd1);
    check("basic_busy_end", 64'(busy_a), 64'd0);

    // ---------------- partial flush, 3x2 frame ----------------
    c = cap_n_b; p = rd_b; d = done_n_b;
    for (int i = 0; i < 7; i++) push_b(8'(8'h11 + i));   // 0x17 must stay unpopped
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    k = 0;
    while (done_n_b < d + 1 && k < 60) begin
      @(negedge clock);
      k++;
    end
    check("partial_timeout", 64'(done_n_b >= d + 1), 64'd1);
    repeat (4) @(negedge clock);
    check("partial_nwords", 64'(cap_n_b - c), 64'd2);
    check("partial_w0_addr", 64'(cap_addr_b[5'(c)]), 64'd0);
    check("partial_w0_data", 64'(cap_data_b[5'(c)]), 64'h14131211);
    check("partial_w1_addr", 64'(cap_addr_b[5'(c + 1)]), 64'd1);
    check("partial_w1_data", 64'(cap_data_b[5'(c + 1)]), 64'h00001615);
    check("partial_pops", 64'(rd_b - p), 64'd6);
    check("partial_done_lat", 64'(done_cyc_b - cap_cyc_b[5'(c + 1)]), 64'd1);

    // ---------------- backpressure ----------------
    c = cap_n_a; p = rd_a; d = done_n_a;
    for (int i = 0; i < 8; i++) push_a(8'(8'h21 + i));
    pulse_start_a();
    k = 0;
    while (!bus_a.mem_wr_en && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("bp_first_wr", 64'(bus_a.mem_wr_en), 64'd1);
    ready_a = 1'b0;
    repeat (5) @(negedge clock);
    check("bp_hold_wr",    64'(bus_a.mem_wr_en),  64'd1);
    check("bp_hold_addr",  64'(bus_a.mem_addr),   64'd0);
    check("bp_hold_data",  64'(bus_a.mem_wdata),  64'h24232221);
    check("bp_hold_pops",  64'(rd_a - p),         64'd8);
    check("bp_hold_rd_en", 64'(bus_a.fifo_rd_en), 64'd0);
    check("bp_hold_busy",  64'(busy_a),           64'd1);
    ready_a = 1'b1;
    wait_done_a("bp_timeout", d + 1, 60);
    repeat (3) @(negedge clock);
    check("bp_nwords", 64'(cap_n_a - c), 64'd2);
    check_word_a("bp_w0", c, 20'd0, 32'h24232221);
    check_word_a("bp_w1", c + 1, 20'd1, 32'h28272625);
    check("bp_stable", 64'(unstable_a), 64'd0);
    check("bp_pops", 64'(rd_a - p), 64'd8);

    // ---------------- empty bubbles ----------------
    c = cap_n_a; p = rd_a; d = done_n_a;
    for (int i = 1; i <= 8; i++) push_a(8'(i));
    bubble_en = 1'b1;
    pulse_start_a();
    wait_done_a("bubble_timeout", d + 1, 80);
    bubble_en = 1'b0;
    repeat (3) @(negedge clock);
    check("bubble_nwords", 64'(cap_n_a - c), 64'd2);
    check_word_a("bubble_w0", c, 20'd0, 32'h04030201);
    check_word_a("bubble_w1", c + 1, 20'd1, 32'h08070605);
    check("bubble_pops", 64'(rd_a - p), 64'd8);
    check("bubble_pop_on_empty", 64'(empty_pop_a), 64'd0);

    // ---------------- async reset mid-frame ----------------
    c = cap_n_a; p = rd_a; d = done_n_a;
    for (int i = 0; i < 8; i++) push_a(8'(8'h31 + i));
    pulse_start_a();
    k = 0;
    while ((rd_a - p) < 3 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("arst_three_pops", 64'(rd_a - p), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_wr_en", 64'(bus_a.mem_wr_en),  64'd0);
    check("arst_addr",  64'(bus_a.mem_addr),   64'd0);
    check("arst_wdata", 64'(bus_a.mem_wdata),  64'd0);
    check("arst_busy",  64'(busy_a),           64'd0);
    check("arst_rd_en", 64'(bus_a.fifo_rd_en), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("arst_no_write", 64'(cap_n_a - c),  64'd0);
    check("arst_no_done",  64'(done_n_a - d), 64'd0);
    check("arst_no_pops",  64'(rd_a - p),     64'd3);
    check("arst_idle",     64'(busy_a),       64'd0);
    // Five pixels 0x34..0x38 remain queued; top up to a full frame.
    for (int i = 0; i < 3; i++) push_a(8'(8'h39 + i));
    pulse_start_a();
    wait_done_a("arst_timeout", d + 1, 60);
    repeat (3) @(negedge clock);
    check("arst_nwords", 64'(cap_n_a - c), 64'd2);
    check_word_a("arst_w0", c, 20'd0, 32'h37363534);
    check_word_a("arst_w1", c + 1, 20'd1, 32'h3b3a3938);

    // ---------------- back-to-back frames ----------------
    c = cap_n_a; p = rd_a; d = done_n_a;
    for (int i = 0; i < 16; i++) push_a(8'(8'h41 + i));
    start_a = 1'b1;
    k = 0;
    while (done_n_a < d + 2 && k < 120) begin
      @(negedge clock);
      k++;
    end
    start_a = 1'b0;
    check("b2b_timeout", 64'(done_n_a >= d + 2), 64'd1);
    repeat (4) @(negedge clock);
    check("b2b_nwords", 64'(cap_n_a - c), 64'd4);
    check_word_a("b2b_f0w0", c,     20'd0, 32'h44434241);
    check_word_a("b2b_f0w1", c + 1, 20'd1, 32'h48474645);
    check_word_a("b2b_f1w0", c + 2, 20'd0, 32'h4c4b4a49);
    check_word_a("b2b_f1w1", c + 3, 20'd1, 32'h504f4e4d);
    check("b2b_ndone", 64'(done_n_a - d), 64'd2);
    check("b2b_done_width", 64'(done_maxrun_a), 64'd1);
    check("b2b_pops", 64'(rd_a - p), 64'd16);
    check("b2b_busy_end", 64'(busy_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
